pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic parametrised pipeline register between any two core stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a DATA payload (PC, imm, operands, rd addr) and a CTRL payload (ALU_src, ALU_ctrl, branch, MemWrite, jal, rd_wen, ...).
//  Adds valid/ready handshake, stall, flush and bubble insertion.
//  Chains DEPTH register slots, so the same block also serves multi-cycle stage boundaries.
// PARAMETERS
//  DATA_W  32  data payload width; not cleared on bubble
//  CTRL_W  16  control payload width; forced to CTRL_NOP on bubble/flush/reset
//  DEPTH   1   number of chained register slots (>=1); latency in cycles
//  CTRL_NOP 0  CTRL_W-bit value presented for a killed/empty slot
//  CNT_W   32  perf counter width (only with PIPE_PERF_EN)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous active-low reset
//  flush      in   1        kill every slot this cycle (branch/jump redirect)
//  in_valid   in   1        upstream holds a valid instruction
//  in_ready   out  1        slot 0 can accept this cycle
//  in_data    in   DATA_W   upstream data payload
//  in_ctrl    in   CTRL_W   upstream control payload
//  out_valid  out  1        last slot holds a valid instruction
//  out_ready  in   1        downstream accepts this cycle (0 = stall)
//  out_data   out  DATA_W   last-slot data payload
//  out_ctrl   out  CTRL_W   last-slot ctrl; CTRL_NOP whenever out_valid=0
//  stall_cnt  out  CNT_W    [PIPE_PERF_EN] cycles with out_valid & !out_ready
//  bubble_cnt out  CNT_W    [PIPE_PERF_EN] cycles with !out_valid
// BEHAVIOUR
//  Reset (rst_n=0, async): every slot valid=0, data=0, ctrl=CTRL_NOP; counters=0. Outputs settle without a clock edge.
//  Slots are numbered 0..DEPTH-1; slot DEPTH-1 drives the out_* ports.
//  - ready[DEPTH-1] = !valid[DEPTH-1] | out_ready.
//  - ready[i] = !valid[i] | ready[i+1].
//  - in_ready = ready[0]. Ready is a combinational chain, which gives full throughput (1 instr/cycle).
//  Transfer into slot i when its upstream is valid and ready[i]=1. The slot captures data and ctrl, and valid<=1.
//  A slot whose content moves on with nothing arriving becomes a bubble: valid<=0, ctrl<=CTRL_NOP, data holds its old value.
//  A slot with ready[i]=0 holds all fields (stall).
//  Latency: DEPTH cycles from in_valid&in_ready to out_valid, with no stalls.
//  Flush has priority over every transfer:
//  - On a clock edge with flush=1, all slots get valid<=0 and ctrl<=CTRL_NOP.
//  - An input accepted in the same cycle is discarded.
//  - in_ready keeps its normal value, so upstream treats the item as consumed.
//  Simultaneous in_valid accept + out_ready drain, full pipe: both happen and occupancy is unchanged.
//  Stall with an upstream bubble: a full slot holds, and the empty slot ahead of it still accepts (bubbles compress).
//  out_ctrl is CTRL_NOP when out_valid=0, so a stray MemWrite or rd_wen can never leak from a killed slot.
//  Reset asserted mid-stream: contents are lost immediately and no partial transfer completes.
// CONFIGURATION
//  Macro PIPE_PERF_EN.
//  - Defined: stall_cnt and bubble_cnt ports exist. Each increments by 1 per clock on its condition.
//  - Counters saturate at 2^CNT_W-1 and clear on reset only. flush does not clear them.
//  - Undefined: counter ports and logic are absent; all other behaviour is identical.
// TESTING
//  1. Reset then DEPTH=1, in_valid=1, data=0x00400000, ctrl=0x0021, out_ready=1:
//     out_valid=1 with identical payload one edge later.
//  2. DEPTH=3, back-to-back stream of 5 items with out_ready=1:
//     first output 3 cycles after first accept, then 1 per cycle, in_ready stays 1.
//  3. Pipe full, out_ready=0 for 4 cycles: in_ready=0, out payload stable.
//     Release: items drain in order with none lost or duplicated.
//  4. flush=1 with in_valid=1 and all slots full:
//     next cycle out_valid=0, out_ctrl=CTRL_NOP, and the flushed input never appears.
//  5. rst_n pulsed low between clock edges mid-stream:
//     outputs go to reset values before the next edge.
//  6. PIPE_PERF_EN, CNT_W=4, 20 stall cycles: stall_cnt=15 (saturated). 3 idle cycles: bubble_cnt=3.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Purpose: generic DEPTH-slot pipeline register carrying data + ctrl payloads, with valid/ready, flush and bubble insertion.
// Latency: DEPTH cycles from accept to out_valid; full throughput of one item per cycle.
// Backpressure: ready is a combinational chain from out_ready back to in_ready; full slots hold and empty slots still fill.
// Optional feature macro: PIPE_PERF_EN adds saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int                 DATA_W   = 32,
    parameter int                 CTRL_W   = 16,
    parameter int                 DEPTH    = 1,
    parameter logic [CTRL_W-1:0]  CTRL_NOP = '0,
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [CTRL_W-1:0] ctrl_q [DEPTH];
    logic [CTRL_W-1:0] ctrl_d [DEPTH];

    logic [DEPTH-1:0]  slot_rdy;
    logic [DEPTH-1:0]  up_vld;
    logic [DATA_W-1:0] up_dat [DEPTH];
    logic [CTRL_W-1:0] up_ctl [DEPTH];

    // Slot i can take new content if it, or any slot downstream of it, is empty, or the sink drains.
    // Written as an OR over downstream slots so no signal feeds back on itself.
    always_comb begin
        logic acc;
        slot_rdy = '0;
        acc      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            acc = out_ready;
            for (int j = i; j < DEPTH; j++) begin
                acc = acc | ~valid_q[j];
            end
            slot_rdy[i] = acc;
        end
    end

    // Source feeding each slot: the input port for slot 0, the previous slot otherwise.
    always_comb begin
        up_vld    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            up_dat[i] = in_data;
            up_ctl[i] = in_ctrl;
        end
        up_vld[0] = in_valid;
        for (int i = 1; i < DEPTH; i++) begin
            up_vld[i] = valid_q[i-1];
            up_dat[i] = data_q[i-1];
            up_ctl[i] = ctrl_q[i-1];
        end
    end

    // Slot next state: flush kills everything, otherwise capture / bubble when ready, hold when stalled.
    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            ctrl_d[i] = ctrl_q[i];
            if (flush) begin
                valid_d[i] = 1'b0;
                ctrl_d[i]  = CTRL_NOP;
            end else if (slot_rdy[i]) begin
                if (up_vld[i]) begin
                    valid_d[i] = 1'b1;
                    data_d[i]  = up_dat[i];
                    ctrl_d[i]  = up_ctl[i];
                end else begin
                    // Data is left alone on a bubble; only ctrl must be neutralised.
                    valid_d[i] = 1'b0;
                    ctrl_d[i]  = CTRL_NOP;
                end
            end
        end
    end

    // Slot state registers; reset empties every slot immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ctrl_q[i] <= CTRL_NOP;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // ctrl is forced to CTRL_NOP whenever a slot empties, so the last slot can drive out_ctrl directly.
    assign in_ready  = slot_rdy[0];
    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_ctrl  = ctrl_q[DEPTH-1];

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d;

    // Saturating counters; only reset clears them, flush does not.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    // Counter width only matters when the counters are built.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a DEPTH=1 instance driven from a vector table,
// and a DEPTH=3 instance exercised with hand-written multi-cycle sequences and a scoreboard.
// Counter checks are compiled in only when PIPE_PERF_EN is defined.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DEPTH=1 instance
    logic        d1_iv, d1_ordy, d1_fl, d1_ir, d1_ov;
    logic [31:0] d1_d, d1_od;
    logic [15:0] d1_c, d1_oc;
    // DEPTH=3 instance
    logic        d3_iv, d3_ordy, d3_fl, d3_ir, d3_ov;
    logic [31:0] d3_d, d3_od;
    logic [15:0] d3_c, d3_oc;
`ifdef PIPE_PERF_EN
    logic [31:0] d1_sc, d1_bc;
    logic [3:0]  d3_sc, d3_bc;
`endif

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(1), .CTRL_NOP(16'h0000), .CNT_W(32)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flush(d1_fl),
        .in_valid(d1_iv), .in_ready(d1_ir), .in_data(d1_d), .in_ctrl(d1_c),
        .out_valid(d1_ov), .out_ready(d1_ordy), .out_data(d1_od), .out_ctrl(d1_oc)
`ifdef PIPE_PERF_EN
        , .stall_cnt(d1_sc), .bubble_cnt(d1_bc)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(3), .CTRL_NOP(16'h0000), .CNT_W(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush(d3_fl),
        .in_valid(d3_iv), .in_ready(d3_ir), .in_data(d3_d), .in_ctrl(d3_c),
        .out_valid(d3_ov), .out_ready(d3_ordy), .out_data(d3_od), .out_ctrl(d3_oc)
`ifdef PIPE_PERF_EN
        , .stall_cnt(d3_sc), .bubble_cnt(d3_bc)
`endif
    );

    int n_run  = 0;
    int n_fail = 0;
    int pop_cnt = 0;
    logic [47:0] exp_q [$];

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [15:0] c;
        logic        ordy;
        logic        fl;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_od;
        logic [15:0] e_oc;
        logic        chk_d;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One cycle on the DEPTH=3 instance with scoreboard tracking; returns at posedge+1.
    task automatic step3(input logic iv, input logic [31:0] d, input logic [15:0] c,
                         input logic ordy, input logic fl, output logic pre_rdy);
        logic [47:0] e;
        @(negedge clk);
        d3_iv = iv; d3_d = d; d3_c = c; d3_ordy = ordy; d3_fl = fl;
        #1;
        pre_rdy = d3_ir;
        if (d3_ov && ordy) begin
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL sb_unexpected: got item %h with nothing expected", d3_od);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", d3_od, e[47:16]);
                chk("sb_ctrl", {16'h0, d3_oc}, {16'h0, e[15:0]});
                pop_cnt++;
            end
        end
        if (fl) exp_q.delete();
        else if (iv && d3_ir) exp_q.push_back({d, c});
        @(posedge clk);
        #1;
    endtask

    task automatic drain3(input int budget);
        logic r;
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && !d3_ov) break;
            step3(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, r);
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;

        //                iv    d             c        ordy  fl    e_rdy e_ov  e_od          e_oc     chk_d
        tbl[0] = '{1'b1, 32'h00400000, 16'h0021, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00400000, 16'h0021, 1'b1};
        tbl[1] = '{1'b1, 32'h00000011, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00400000, 16'h0021, 1'b1};
        tbl[2] = '{1'b1, 32'h00000011, 16'h0005, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000011, 16'h0005, 1'b1};
        tbl[3] = '{1'b0, 32'h00000022, 16'h0007, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000011, 16'h0000, 1'b1};
        tbl[4] = '{1'b0, 32'h00000022, 16'h0007, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00000011, 16'h0000, 1'b1};
        tbl[5] = '{1'b1, 32'h00000033, 16'h0009, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00000033, 16'h0009, 1'b1};
        tbl[6] = '{1'b1, 32'h00000044, 16'h000A, 1'b1, 1'b1, 1'b1, 1'b0, 32'h00000000, 16'h0000, 1'b0};
        tbl[7] = '{1'b1, 32'h00000055, 16'h000B, 1'b1, 1'b0, 1'b1, 1'b1, 32'h00000055, 16'h000B, 1'b1};
        tbl[8] = '{1'b0, 32'h00000000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, 16'h0000, 1'b0};
        tbl[9] = '{1'b0, 32'h00000000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00000000, 16'h0000, 1'b0};

        rst_n = 1'b0;
        d1_iv = 0; d1_ordy = 0; d1_fl = 0; d1_d = 0; d1_c = 0;
        d3_iv = 0; d3_ordy = 0; d3_fl = 0; d3_d = 0; d3_c = 0;
        #2;
        chk("rst_d1_out_valid", d1_ov, 0);
        chk("rst_d1_out_ctrl",  d1_oc, 0);
        chk("rst_d1_out_data",  d1_od, 0);
        chk("rst_d1_in_ready",  d1_ir, 1);
        chk("rst_d3_out_valid", d3_ov, 0);
        chk("rst_d3_out_ctrl",  d3_oc, 0);
        chk("rst_d3_out_data",  d3_od, 0);
        chk("rst_d3_in_ready",  d3_ir, 1);
`ifdef PIPE_PERF_EN
        chk("rst_d1_stall_cnt",  d1_sc, 0);
        chk("rst_d1_bubble_cnt", d1_bc, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // DEPTH=1 vector table
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            d1_iv = tbl[i].iv; d1_d = tbl[i].d; d1_c = tbl[i].c;
            d1_ordy = tbl[i].ordy; d1_fl = tbl[i].fl;
            #1;
            chk($sformatf("vec%0d_in_ready", i), d1_ir, tbl[i].e_rdy);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), d1_ov, tbl[i].e_ov);
            chk($sformatf("vec%0d_out_ctrl", i), d1_oc, tbl[i].e_oc);
            if (tbl[i].chk_d) chk($sformatf("vec%0d_out_data", i), d1_od, tbl[i].e_od);
        end
        @(negedge clk);
        d1_iv = 0; d1_fl = 0; d1_ordy = 1;

        // DEPTH=3 back-to-back stream: first output after the third edge, then one per cycle
        pop_cnt = 0;
        for (int c = 0; c < 7; c++) begin
            step3(c < 5, 32'hA0000000 + 32'(c), 16'h0100 + 16'(c), 1'b1, 1'b0, r);
            if (c < 5) chk($sformatf("t2_in_ready_c%0d", c), r, 1);
            chk($sformatf("t2_out_valid_c%0d", c), d3_ov, (c >= 2));
        end
        drain3(10);
        chk("t2_count", pop_cnt, 5);

        // Fill, stall 4 cycles, release and drain in order
        pop_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            step3(1'b1, 32'hB0000000 + 32'(k), 16'h0200 + 16'(k), 1'b0, 1'b0, r);
            chk($sformatf("t3_fill_rdy%0d", k), r, 1);
        end
        for (int k = 0; k < 4; k++) begin
            step3(1'b1, 32'hB0000003, 16'h0203, 1'b0, 1'b0, r);
            chk($sformatf("t3_stall_rdy%0d", k), r, 0);
            chk($sformatf("t3_stall_ov%0d", k), d3_ov, 1);
            chk($sformatf("t3_stall_od%0d", k), d3_od, 32'hB0000000);
        end
        step3(1'b1, 32'hB0000003, 16'h0203, 1'b1, 1'b0, r);
        chk("t3_release_rdy", r, 1);
        chk("t3_full_after_swap", d3_od, 32'hB0000001);
        step3(1'b1, 32'hB0000004, 16'h0204, 1'b1, 1'b0, r);
        drain3(10);
        chk("t3_count", pop_cnt, 5);

        // Flush a full pipe together with a concurrent input
        pop_cnt = 0;
        for (int k = 0; k < 3; k++) step3(1'b1, 32'hC0000000 + 32'(k), 16'h0300 + 16'(k), 1'b0, 1'b0, r);
        step3(1'b1, 32'hDEAD0001, 16'h00FF, 1'b1, 1'b1, r);
        chk("t4_flush_in_ready", r, 1);
        chk("t4_out_valid", d3_ov, 0);
        chk("t4_out_ctrl", d3_oc, 0);
        for (int k = 0; k < 4; k++) begin
            step3(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, r);
            chk($sformatf("t4_post_ov%0d", k), d3_ov, 0);
        end
        chk("t4_count", pop_cnt, 1);

        // Asynchronous reset between edges with a full pipe
        for (int k = 0; k < 3; k++) step3(1'b1, 32'hF0000000 + 32'(k), 16'h0400 + 16'(k), 1'b0, 1'b0, r);
        chk("t5_pre_ov", d3_ov, 1);
        d3_iv = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ov", d3_ov, 0);
        chk("t5_rst_oc", d3_oc, 0);
        chk("t5_rst_od", d3_od, 0);
        chk("t5_rst_ir", d3_ir, 1);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef PIPE_PERF_EN
        chk("t6_stall_cnt0",  d3_sc, 0);
        chk("t6_bubble_cnt0", d3_bc, 0);
        for (int k = 0; k < 3; k++) step3(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, r);
        chk("t6_bubble_cnt3", d3_bc, 3);
        chk("t6_stall_cnt_idle", d3_sc, 0);
        for (int k = 0; k < 3; k++) step3(1'b1, 32'hE0000000 + 32'(k), 16'h0500 + 16'(k), 1'b0, 1'b0, r);
        for (int k = 0; k < 20; k++) step3(1'b1, 32'hE0000003, 16'h0503, 1'b0, 1'b0, r);
        chk("t6_stall_sat", d3_sc, 15);
        chk("t6_bubble_cnt6", d3_bc, 6);
        drain3(10);
`else
        step3(1'b0, 32'h0, 16'h0, 1'b1, 1'b0, r);
        chk("t6_no_ghost_after_reset", d3_ov, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
